// File: rtl/mem_lsu.sv
// MEM-stage load/store unit between EX and WB.
// Loads and stores go out on a valid/grant/rvalid bus with byte strobes.
// Non-memory instructions reach WB through one register stage.
// Illegal or misaligned accesses raise a one-cycle trap and never touch the bus.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | sample EX; pass non-mem ops, trap bad accesses, accept mem ops
// S_REQ  | bus_req_o held with captured fields until bus_gnt_i
// S_WAIT | waiting for bus_rvalid_i; load data goes to WB on arrival
module mem_lsu #(
    parameter int          XLEN      = 32,
    parameter logic [31:0] HALT_ADDR = 32'h0000_1000
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 ex_valid_i,
    input  logic [4:0]           rd_addr_i,
    input  logic [XLEN-1:0]      rd_data_i,
    input  logic                 rd_we_i,
    input  logic [XLEN-1:0]      mem_addr_i,
    input  logic                 mem_re_i,
    input  logic                 mem_we_i,
    input  logic [2:0]           opfunc3_i,
    output logic                 bus_req_o,
    output logic                 bus_we_o,
    output logic [XLEN-1:0]      bus_addr_o,
    output logic [XLEN-1:0]      bus_wdata_o,
    output logic [XLEN/8-1:0]    bus_wstrb_o,
    input  logic                 bus_gnt_i,
    input  logic                 bus_rvalid_i,
    input  logic [XLEN-1:0]      bus_rdata_i,
    output logic                 stall_o,
    output logic [4:0]           rd_addr_o,
    output logic [XLEN-1:0]      rd_data_o,
    output logic                 rd_we_o,
    output logic                 exc_o,
    output logic [1:0]           exc_cause_o,
    output logic [XLEN-1:0]      exc_addr_o,
    output logic                 halt_o
);
    localparam int STRB_W = XLEN / 8;
    localparam int OFF_W  = $clog2(STRB_W);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
    state_t r_state, w_state_nxt;

    logic                 w_mem_op, w_width_ok, w_illegal, w_misal, w_trap, w_accept, w_halt_hit;
    logic [1:0]           w_cause;
    logic [OFF_W-1:0]     w_off;
    logic [STRB_W-1:0]    w_strb_base, w_strb;
    logic [XLEN-1:0]      w_wdata, w_shift, w_ld_data;
    logic                 w_stall, w_bus_req;

    logic [XLEN-1:0]      r_addr, r_wdata;
    logic [STRB_W-1:0]    r_wstrb;
    logic [OFF_W-1:0]     r_off;
    logic [2:0]           r_f3;
    logic [4:0]           r_rd;
    logic                 r_rd_we, r_is_load, r_we;
    logic [4:0]           r_rd_addr_o;
    logic [XLEN-1:0]      r_rd_data_o, r_exc_addr;
    logic                 r_rd_we_o, r_exc, r_halt;
    logic [1:0]           r_exc_cause;

    // Decode the EX slot: width legality, alignment, strobes and lane-replicated store data.
    always_comb begin
        w_mem_op = ex_valid_i & (mem_re_i | mem_we_i);
        w_off    = mem_addr_i[OFF_W-1:0];
        case (opfunc3_i)
            3'b000, 3'b001, 3'b010: w_width_ok = 1'b1;
            3'b100, 3'b101:         w_width_ok = ~mem_we_i;
            3'b011:                 w_width_ok = (XLEN == 64);
            3'b110:                 w_width_ok = (XLEN == 64) & ~mem_we_i;
            default:                w_width_ok = 1'b0;
        endcase
        w_illegal = (mem_re_i & mem_we_i) | ~w_width_ok;
        case (opfunc3_i[1:0])
            2'b01:   w_misal = mem_addr_i[0];
            2'b10:   w_misal = |mem_addr_i[1:0];
            2'b11:   w_misal = |mem_addr_i[2:0];
            default: w_misal = 1'b0;
        endcase
        w_trap     = w_mem_op & (w_illegal | w_misal);
        w_accept   = w_mem_op & ~w_illegal & ~w_misal;
        w_cause    = w_illegal ? 2'b11 : (mem_we_i ? 2'b10 : 2'b01);
        w_halt_hit = w_accept & mem_we_i & (opfunc3_i == 3'b010) &
                     (mem_addr_i == XLEN'(HALT_ADDR));
        case (opfunc3_i[1:0])
            2'b00: begin
                w_strb_base = STRB_W'(1);
                w_wdata     = {STRB_W{rd_data_i[7:0]}};
            end
            2'b01: begin
                w_strb_base = STRB_W'(3);
                w_wdata     = {(STRB_W/2){rd_data_i[15:0]}};
            end
            2'b10: begin
                w_strb_base = STRB_W'(15);
                w_wdata     = {(STRB_W/4){rd_data_i[31:0]}};
            end
            default: begin
                w_strb_base = '1;
                w_wdata     = rd_data_i;
            end
        endcase
        w_strb = mem_we_i ? (w_strb_base << w_off) : '0;
    end

    // Pick the addressed lane out of the read data and extend it to XLEN.
    always_comb begin
        w_shift = bus_rdata_i >> {r_off, 3'b000};
        case (r_f3)
            3'b000:  w_ld_data = XLEN'($signed(w_shift[7:0]));
            3'b100:  w_ld_data = XLEN'(w_shift[7:0]);
            3'b001:  w_ld_data = XLEN'($signed(w_shift[15:0]));
            3'b101:  w_ld_data = XLEN'(w_shift[15:0]);
            3'b010:  w_ld_data = XLEN'($signed(w_shift[31:0]));
            3'b110:  w_ld_data = XLEN'(w_shift[31:0]);
            default: w_ld_data = w_shift;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next-state, bus request and stall.
    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        w_bus_req   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_stall = w_accept;
                if (w_accept) w_state_nxt = S_REQ;
            end
            S_REQ: begin
                w_stall   = 1'b1;
                w_bus_req = 1'b1;
                if (bus_gnt_i) w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_stall = ~bus_rvalid_i;
                if (bus_rvalid_i) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Capture accepted accesses, drive WB, latch traps and the sticky halt flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_off       <= '0;
            r_f3        <= '0;
            r_rd        <= '0;
            r_rd_we     <= 1'b0;
            r_is_load   <= 1'b0;
            r_we        <= 1'b0;
            r_rd_addr_o <= '0;
            r_rd_data_o <= '0;
            r_rd_we_o   <= 1'b0;
            r_exc       <= 1'b0;
            r_exc_cause <= '0;
            r_exc_addr  <= '0;
            r_halt      <= 1'b0;
        end else begin
            r_exc <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr    <= {mem_addr_i[XLEN-1:OFF_W], {OFF_W{1'b0}}};
                        r_off     <= w_off;
                        r_f3      <= opfunc3_i;
                        r_rd      <= rd_addr_i;
                        r_rd_we   <= rd_we_i;
                        r_is_load <= mem_re_i;
                        r_we      <= mem_we_i;
                        r_wdata   <= w_wdata;
                        r_wstrb   <= w_strb;
                        r_rd_we_o <= 1'b0;
                        if (w_halt_hit) r_halt <= 1'b1;
                    end else if (w_trap) begin
                        r_rd_we_o   <= 1'b0;
                        r_exc       <= 1'b1;
                        r_exc_cause <= w_cause;
                        r_exc_addr  <= mem_addr_i;
                    end else begin
                        r_rd_addr_o <= rd_addr_i;
                        r_rd_data_o <= rd_data_i;
                        r_rd_we_o   <= ex_valid_i & rd_we_i;
                    end
                end
                S_WAIT: begin
                    if (bus_rvalid_i) begin
                        r_rd_addr_o <= r_rd;
                        r_rd_we_o   <= r_is_load & r_rd_we;
                        r_rd_data_o <= r_is_load ? w_ld_data : '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus_req_o   = w_bus_req;
    assign bus_we_o    = r_we;
    assign bus_addr_o  = r_addr;
    assign bus_wdata_o = r_wdata;
    assign bus_wstrb_o = r_wstrb;
    assign stall_o     = w_stall & rst_ni;
    assign rd_addr_o   = r_rd_addr_o;
    assign rd_data_o   = r_rd_data_o;
    assign rd_we_o     = r_rd_we_o;
    assign exc_o       = r_exc;
    assign exc_cause_o = r_exc_cause;
    assign exc_addr_o  = r_exc_addr;
    assign halt_o      = r_halt;
endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: one XLEN=32 and one XLEN=64 instance share a bus responder.
module tb_mem_lsu;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        v32, v64;
    logic [4:0]  rd_i;
    logic [63:0] data_i, addr_i;
    logic        rdwe_i, re_i, we_i;
    logic [2:0]  f3_i;
    logic        gnt, rvalid;
    logic [63:0] rdata;
    int          gnt_dly, rv_dly;
    logic [63:0] rsp_data;

    logic        req32, bwe32, stall32, rdwe32, exc32, halt32;
    logic [31:0] baddr32, bwdata32, rdd32, eaddr32;
    logic [3:0]  bstrb32;
    logic [4:0]  rda32;
    logic [1:0]  cause32;

    logic        req64, bwe64, stall64, rdwe64, exc64, halt64;
    logic [63:0] baddr64, bwdata64, rdd64, eaddr64;
    logic [7:0]  bstrb64;
    logic [4:0]  rda64;
    logic [1:0]  cause64;

    mem_lsu #(.XLEN(32)) dut32 (
        .clk_i(clk), .rst_ni(rst_n), .ex_valid_i(v32), .rd_addr_i(rd_i), .rd_data_i(data_i[31:0]),
        .rd_we_i(rdwe_i), .mem_addr_i(addr_i[31:0]), .mem_re_i(re_i), .mem_we_i(we_i),
        .opfunc3_i(f3_i), .bus_req_o(req32), .bus_we_o(bwe32), .bus_addr_o(baddr32),
        .bus_wdata_o(bwdata32), .bus_wstrb_o(bstrb32), .bus_gnt_i(gnt), .bus_rvalid_i(rvalid),
        .bus_rdata_i(rdata[31:0]), .stall_o(stall32), .rd_addr_o(rda32), .rd_data_o(rdd32),
        .rd_we_o(rdwe32), .exc_o(exc32), .exc_cause_o(cause32), .exc_addr_o(eaddr32), .halt_o(halt32));

    mem_lsu #(.XLEN(64)) dut64 (
        .clk_i(clk), .rst_ni(rst_n), .ex_valid_i(v64), .rd_addr_i(rd_i), .rd_data_i(data_i),
        .rd_we_i(rdwe_i), .mem_addr_i(addr_i), .mem_re_i(re_i), .mem_we_i(we_i),
        .opfunc3_i(f3_i), .bus_req_o(req64), .bus_we_o(bwe64), .bus_addr_o(baddr64),
        .bus_wdata_o(bwdata64), .bus_wstrb_o(bstrb64), .bus_gnt_i(gnt), .bus_rvalid_i(rvalid),
        .bus_rdata_i(rdata), .stall_o(stall64), .rd_addr_o(rda64), .rd_data_o(rdd64),
        .rd_we_o(rdwe64), .exc_o(exc64), .exc_cause_o(cause64), .exc_addr_o(eaddr64), .halt_o(halt64));

    typedef struct {logic [63:0] addr; logic we; logic [7:0] wstrb; logic [63:0] wdata;} bus_t;
    typedef struct {logic [4:0] rd; logic [63:0] data;} wb_t;
    typedef struct {logic [1:0] cause; logic [63:0] addr;} exc_t;

    bus_t bq32[$], bq64[$];
    wb_t  wq32[$], wq64[$];
    exc_t eq32[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic unexp(input string nm, input logic [63:0] act);
        n_cmp++;
        n_err++;
        $display("FAIL %s: unexpected output %h, none expected", nm, act);
    endtask

    task automatic pb(input bit s64, input logic [63:0] a, input logic w, input logic [7:0] s,
                      input logic [63:0] d);
        bus_t t;
        t.addr = a; t.we = w; t.wstrb = s; t.wdata = d;
        if (s64) bq64.push_back(t); else bq32.push_back(t);
    endtask

    task automatic pw(input bit s64, input logic [4:0] r, input logic [63:0] d);
        wb_t t;
        t.rd = r; t.data = d;
        if (s64) wq64.push_back(t); else wq32.push_back(t);
    endtask

    task automatic pe(input logic [1:0] c, input logic [63:0] a);
        exc_t t;
        t.cause = c; t.addr = a;
        eq32.push_back(t);
    endtask

    // Bus slave: grant after gnt_dly cycles, respond rv_dly cycles after the grant.
    initial begin
        gnt = 1'b0; rvalid = 1'b0; rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (req32 || req64) begin
                repeat (gnt_dly) begin @(posedge clk); #1; end
                gnt = 1'b1;
                @(posedge clk); #1;
                gnt = 1'b0;
                repeat (rv_dly) begin @(posedge clk); #1; end
                rvalid = 1'b1; rdata = rsp_data;
                @(posedge clk); #1;
                rvalid = 1'b0; rdata = '0;
            end
        end
    end

    // Monitor for the 32-bit instance.
    logic        ph32;
    logic [31:0] pa32, pd32;
    logic [3:0]  ps32;
    logic        pwe32;
    always @(negedge clk) begin : mon32
        bus_t b; wb_t w; exc_t e;
        if (rst_n) begin
            if (req32 && ph32) begin
                chk("req32_addr_stable", baddr32, pa32);
                chk("req32_wdata_stable", bwdata32, pd32);
                chk("req32_wstrb_stable", bstrb32, ps32);
                chk("req32_we_stable", bwe32, pwe32);
            end
            if (req32 && gnt) begin
                if (bq32.size() == 0) unexp("bus32", baddr32);
                else begin
                    b = bq32.pop_front();
                    chk("bus32_addr", baddr32, b.addr);
                    chk("bus32_we", bwe32, b.we);
                    chk("bus32_wstrb", bstrb32, b.wstrb);
                    if (b.we) chk("bus32_wdata", bwdata32, b.wdata);
                end
            end
            if (rdwe32) begin
                if (wq32.size() == 0) unexp("wb32", rdd32);
                else begin
                    w = wq32.pop_front();
                    chk("wb32_rd", rda32, w.rd);
                    chk("wb32_data", rdd32, w.data);
                end
            end
            if (exc32) begin
                if (eq32.size() == 0) unexp("exc32", eaddr32);
                else begin
                    e = eq32.pop_front();
                    chk("exc32_cause", cause32, e.cause);
                    chk("exc32_addr", eaddr32, e.addr);
                end
            end
        end
        ph32 = req32 && !gnt; pa32 = baddr32; pd32 = bwdata32; ps32 = bstrb32; pwe32 = bwe32;
    end

    // Monitor for the 64-bit instance.
    always @(negedge clk) begin : mon64
        bus_t b; wb_t w;
        if (rst_n) begin
            if (req64 && gnt) begin
                if (bq64.size() == 0) unexp("bus64", baddr64);
                else begin
                    b = bq64.pop_front();
                    chk("bus64_addr", baddr64, b.addr);
                    chk("bus64_we", bwe64, b.we);
                    chk("bus64_wstrb", bstrb64, b.wstrb);
                    if (b.we) chk("bus64_wdata", bwdata64, b.wdata);
                end
            end
            if (rdwe64) begin
                if (wq64.size() == 0) unexp("wb64", rdd64);
                else begin
                    w = wq64.pop_front();
                    chk("wb64_rd", rda64, w.rd);
                    chk("wb64_data", rdd64, w.data);
                end
            end
            if (exc64) unexp("exc64", eaddr64);
        end
    end

    // Present one EX slot, hold it while stalled, and count stall cycles.
    task automatic issue(input bit s64, input bit vld, input logic [4:0] rd, input logic [63:0] data,
                         input bit rwe, input logic [63:0] addr, input bit re, input bit we,
                         input logic [2:0] f3, input int exp_stall, input string nm);
        int st = 0;
        bit done = 1'b0;
        rd_i = rd; data_i = data; rdwe_i = rwe; addr_i = addr; re_i = re; we_i = we; f3_i = f3;
        v32 = vld & !s64;
        v64 = vld & s64;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (s64 ? stall64 : stall32) st++;
            else done = 1'b1;
            @(posedge clk); #1;
        end
        v32 = 1'b0; v64 = 1'b0; re_i = 1'b0; we_i = 1'b0; rdwe_i = 1'b0;
        chk({nm, "_stall"}, st, exp_stall);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; v32 = 1'b0; v64 = 1'b0;
        rd_i = '0; data_i = '0; rdwe_i = 1'b0; addr_i = '0; re_i = 1'b0; we_i = 1'b0; f3_i = '0;
        gnt_dly = 0; rv_dly = 0; rsp_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst32_outputs", |{req32, bwe32, baddr32, bwdata32, bstrb32, stall32, rda32, rdd32,
                               rdwe32, exc32, cause32, eaddr32, halt32}, 0);
        chk("rst64_outputs", |{req64, bwe64, baddr64, bwdata64, bstrb64, stall64, rda64, rdd64,
                               rdwe64, exc64, cause64, eaddr64, halt64}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        pw(0, 5'd3, 64'h55);
        issue(0, 1, 5'd3, 64'h55, 1, 64'h0, 0, 0, 3'b000, 0, "add");
        issue(0, 0, 5'd4, 64'h66, 1, 64'h0, 0, 0, 3'b000, 0, "bubble");

        rsp_data = 64'h80AB_CDEF;
        pb(0, 64'h100, 1'b0, 8'h0, 64'h0);
        pw(0, 5'd5, 64'hFFFF_FF80);
        issue(0, 1, 5'd5, 64'h0, 1, 64'h103, 1, 0, 3'b000, 2, "lb");

        rsp_data = 64'h8765_4321;
        pb(0, 64'h100, 1'b0, 8'h0, 64'h0);
        pw(0, 5'd6, 64'h8765);
        issue(0, 1, 5'd6, 64'h0, 1, 64'h102, 1, 0, 3'b101, 2, "lhu");

        rsp_data = 64'h0;
        pb(0, 64'h100, 1'b1, 8'b1100, 64'h1234_1234);
        issue(0, 1, 5'd8, 64'hABCD_1234, 1, 64'h102, 0, 1, 3'b001, 2, "sh");

        pb(0, 64'h100, 1'b1, 8'b0010, 64'hA5A5_A5A5);
        issue(0, 1, 5'd0, 64'h0000_00A5, 0, 64'h101, 0, 1, 3'b000, 2, "sb");

        pe(2'b01, 64'h101);
        issue(0, 1, 5'd9, 64'h0, 1, 64'h101, 1, 0, 3'b010, 0, "lw_misal");
        pe(2'b10, 64'h103);
        issue(0, 1, 5'd0, 64'h0, 0, 64'h103, 0, 1, 3'b001, 0, "sh_misal");
        pe(2'b11, 64'h100);
        issue(0, 1, 5'd9, 64'h0, 1, 64'h100, 1, 1, 3'b010, 0, "re_we");
        pe(2'b11, 64'h108);
        issue(0, 1, 5'd9, 64'h0, 1, 64'h108, 1, 0, 3'b011, 0, "ld_on32");
        pe(2'b11, 64'h10C);
        issue(0, 1, 5'd0, 64'h0, 0, 64'h10C, 0, 1, 3'b100, 0, "sbu_store");

        gnt_dly = 3; rv_dly = 2; rsp_data = 64'hDEAD_BEEF;
        pb(0, 64'h108, 1'b0, 8'h0, 64'h0);
        pw(0, 5'd7, 64'hDEAD_BEEF);
        issue(0, 1, 5'd7, 64'h0, 1, 64'h108, 1, 0, 3'b010, 7, "lw_slow");
        gnt_dly = 0; rv_dly = 0;

        // Reset while a request is outstanding; the late grant and rvalid must be ignored.
        gnt_dly = 5; rsp_data = 64'h1234;
        rd_i = 5'd9; addr_i = 64'h200; re_i = 1'b1; we_i = 1'b0; f3_i = 3'b010; rdwe_i = 1'b1;
        v32 = 1'b1;
        @(posedge clk); #1;
        v32 = 1'b0; re_i = 1'b0; rdwe_i = 1'b0;
        @(posedge clk); #3;
        chk("mid_req_req_before", req32, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_req_req_after", req32, 0);
        chk("mid_req_outputs", |{req32, bwe32, baddr32, bwdata32, bstrb32, stall32, rda32, rdd32,
                                 rdwe32, exc32, cause32, eaddr32, halt32}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        gnt_dly = 0;
        pw(0, 5'd10, 64'h77);
        issue(0, 1, 5'd10, 64'h77, 1, 64'h0, 0, 0, 3'b000, 0, "add_after_rst");

        rsp_data = 64'hFFFF_FFFF_0000_0000;
        pb(1, 64'h0, 1'b0, 8'h0, 64'h0);
        pw(1, 5'd9, 64'h0000_0000_FFFF_FFFF);
        issue(1, 1, 5'd9, 64'h0, 1, 64'h4, 1, 0, 3'b110, 2, "lwu64");

        rsp_data = 64'h8000_0000_1234_5678;
        pb(1, 64'h0, 1'b0, 8'h0, 64'h0);
        pw(1, 5'd11, 64'hFFFF_FFFF_8000_0000);
        issue(1, 1, 5'd11, 64'h0, 1, 64'h4, 1, 0, 3'b010, 2, "lw64");

        rsp_data = 64'h0123_4567_89AB_CDEF;
        pb(1, 64'h10, 1'b0, 8'h0, 64'h0);
        pw(1, 5'd12, 64'h0123_4567_89AB_CDEF);
        issue(1, 1, 5'd12, 64'h0, 1, 64'h10, 1, 0, 3'b011, 2, "ld64");
        chk("halt64_before", halt64, 0);

        rsp_data = 64'h0;
        pb(1, 64'h1000, 1'b1, 8'h0F, 64'h0000_0001_0000_0001);
        issue(1, 1, 5'd0, 64'h1, 0, 64'h1000, 0, 1, 3'b010, 2, "sw_halt");
        chk("halt64_set", halt64, 1);

        pw(1, 5'd13, 64'hFEDC_BA98_7654_3210);
        issue(1, 1, 5'd13, 64'hFEDC_BA98_7654_3210, 1, 64'h0, 0, 0, 3'b000, 0, "add64");
        repeat (3) begin @(posedge clk); #1; end
        chk("halt64_sticky", halt64, 1);
        chk("halt32_clear", halt32, 0);

        chk("bq32_left", bq32.size(), 0);
        chk("wq32_left", wq32.size(), 0);
        chk("eq32_left", eq32.size(), 0);
        chk("bq64_left", bq64.size(), 0);
        chk("wq64_left", wq64.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
